// File: rtl/coffee_order_driver.sv
// coffee_order_driver: turns a requested coffee type into timed active-low next/select presses.
// Latency: buttons move one edge after accept; done lands (presses+1)*(HOLD+GAP)+1 cycles after accept.
// Backpressure: req_ready is high only in IDLE; req_valid while busy is dropped, not queued.
// Optional feature macro: ORDER_CANCEL_EN adds a cancel input that aborts an order during its next presses.
module coffee_order_driver #(
  parameter int HOLD_CYCLES = 30,
  parameter int GAP_CYCLES  = 30,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_type,
`ifdef ORDER_CANCEL_EN
  input  logic       cancel,
`endif
  output logic       req_ready,
  output logic       next_button,
  output logic       select_button,
  output logic [1:0] cur_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    NEXT_LOW,
    NEXT_GAP,
    SEL_LOW,
    SEL_GAP,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       rem, rem_nxt;
  logic [1:0]       sel_nxt;
  logic             aborting, aborting_nxt;
  logic             accept;
  logic             cancel_hit;
  logic [2:0]       diff;
  logic [1:0]       presses;

  assign accept = req_valid && req_ready;

`ifdef ORDER_CANCEL_EN
  assign cancel_hit = cancel && ((state == NEXT_LOW) || (state == NEXT_GAP));
`else
  assign cancel_hit = 1'b0;
`endif

  // Number of "next" presses needed: (req_type - cur_sel) mod 3 over the three valid types
  always_comb begin
    diff    = {1'b0, req_type} + 3'd3 - {1'b0, cur_sel};
    presses = (diff >= 3'd3) ? 2'(diff - 3'd3) : diff[1:0];
  end

  // Next-state logic: hold/gap timing, remaining press count and selection mirror
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + CNT_W'(1);
    rem_nxt      = rem;
    sel_nxt      = cur_sel;
    aborting_nxt = aborting;
    case (state)
      IDLE: begin
        cnt_nxt      = '0;
        aborting_nxt = 1'b0;
        // An invalid type (11) is accepted but starts nothing; err is raised separately
        if (accept && (req_type != 2'b11)) begin
          rem_nxt   = presses;
          state_nxt = (presses != 2'd0) ? NEXT_LOW : SEL_LOW;
        end
      end
      NEXT_LOW: begin
        if (cancel_hit) begin
          // Abandoned press does not count: mirror stays on the last completed press
          state_nxt    = NEXT_GAP;
          cnt_nxt      = '0;
          aborting_nxt = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = NEXT_GAP;
          cnt_nxt   = '0;
          rem_nxt   = rem - 2'd1;
          sel_nxt   = (cur_sel == 2'd2) ? 2'd0 : cur_sel + 2'd1;
        end
      end
      NEXT_GAP: begin
        if (cancel_hit) begin
          cnt_nxt      = '0;
          aborting_nxt = 1'b1;
        end else if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (aborting)
            state_nxt = IDLE;
          else if (rem != 2'd0)
            state_nxt = NEXT_LOW;
          else
            state_nxt = SEL_LOW;
        end
      end
      SEL_LOW: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = SEL_GAP;
          cnt_nxt   = '0;
        end
      end
      SEL_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters and selection mirror
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      cur_sel  <= 2'd0;
      aborting <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rem      <= rem_nxt;
      cur_sel  <= sel_nxt;
      aborting <= aborting_nxt;
    end
  end

  // Registered outputs; buttons follow the state one edge later, cancel releases next at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_button   <= 1'b1;
      select_button <= 1'b1;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      next_button   <= !((state == NEXT_LOW) && !cancel_hit);
      select_button <= !(state == SEL_LOW);
      req_ready     <= (state_nxt == IDLE);
      busy          <= (state_nxt != IDLE);
      done          <= (state == DONE);
      err           <= accept && (req_type == 2'b11);
    end
  end

endmodule

// File: tb/tb_coffee_order_driver.sv
// Bench for coffee_order_driver: directed order table plus hand sequences for reset,
// held req_valid, invalid type and (when ORDER_CANCEL_EN is defined) cancel.
module tb_coffee_order_driver;

  localparam int H = 30;
  localparam int G = 30;
  localparam int P = H + G;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_type;
  logic       req_ready, next_button, select_button, busy, done, err;
  logic [1:0] cur_sel;
`ifdef ORDER_CANCEL_EN
  logic       cancel;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int both_low = 0;

  coffee_order_driver #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_type(req_type),
`ifdef ORDER_CANCEL_EN
    .cancel(cancel),
`endif
    .req_ready(req_ready),
    .next_button(next_button),
    .select_button(select_button),
    .cur_sel(cur_sel),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // Both buttons must never be pressed together
  always @(negedge clk) begin
    if (reset === 1'b0 && next_button === 1'b0 && select_button === 1'b0)
      both_low++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Called just after the accept edge; checks every cycle until done is expected
  task automatic run_wave(input int p, input string nm);
    int d;
    int bad_nb, bad_sb, bad_busy, done_at;
    bit en, es;
    d = (p + 1) * P + 1;
    bad_nb = 0; bad_sb = 0; bad_busy = 0; done_at = -1;
    for (int k = 1; k <= d + 2 && done_at < 0; k++) begin
      @(posedge clk); #1;
      en = (k <= P * p) && (((k - 1) % P) < H);
      es = (k > P * p) && (k <= P * p + H);
      if (next_button !== !en) bad_nb++;
      if (select_button !== !es) bad_sb++;
      if (busy !== (k < d)) bad_busy++;
      if (done === 1'b1) done_at = k;
    end
    chk({nm, " next_wave_errs"}, bad_nb, 0);
    chk({nm, " sel_wave_errs"}, bad_sb, 0);
    chk({nm, " busy_wave_errs"}, bad_busy, 0);
    chk({nm, " done_cycle"}, done_at, d);
    chk({nm, " req_ready_at_done"}, int'(req_ready), 1);
  endtask

  typedef struct {
    logic [1:0] req_type;
    int         presses;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int bad;
    vecs[0] = '{2'd2, 2, 2'd2};
    vecs[1] = '{2'd0, 1, 2'd0};
    vecs[2] = '{2'd0, 0, 2'd0};
    vecs[3] = '{2'd1, 1, 2'd1};
    vecs[4] = '{2'd3, 0, 2'd1};
    vecs[5] = '{2'd1, 0, 2'd1};
    vecs[6] = '{2'd0, 2, 2'd0};
    vecs[7] = '{2'd2, 2, 2'd2};
    vecs[8] = '{2'd2, 0, 2'd2};

    req_valid = 1'b0;
    req_type  = 2'd0;
`ifdef ORDER_CANCEL_EN
    cancel = 1'b0;
`endif
    reset = 1'b1;

    // Reset held for 10 cycles: outputs at reset values throughout
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (next_button !== 1'b1 || select_button !== 1'b1 || cur_sel !== 2'd0 ||
          req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
        bad++;
    end
    chk("reset_hold_errs", bad, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table of orders applied back to back
    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      req_type  = vecs[i].req_type;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (vecs[i].req_type == 2'b11) begin
        chk({nm, " err_pulse"}, int'(err), 1);
        chk({nm, " ready_kept"}, int'(req_ready), 1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          if (err !== 1'b0 || next_button !== 1'b1 || select_button !== 1'b1 ||
              busy !== 1'b0 || req_ready !== 1'b1)
            bad++;
        end
        chk({nm, " idle_after_err_errs"}, bad, 0);
      end else begin
        run_wave(vecs[i].presses, nm);
      end
      chk({nm, " cur_sel"}, int'(cur_sel), int'(vecs[i].exp_sel));
    end

    // req_valid held through a sequence with a changed type: only taken after IDLE
    req_type  = 2'd1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_type = 2'd0;
    run_wave(2, "held_first");
    chk("held_first cur_sel", int'(cur_sel), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    run_wave(2, "held_second");
    chk("held_second cur_sel", int'(cur_sel), 0);

    // Reset during NEXT_LOW, observed before any further clock edge
    req_type  = 2'd2;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset next_low", int'(next_button), 0);
    #1 reset = 1'b1;
    #1;
    chk("async_reset next_button", int'(next_button), 1);
    chk("async_reset cur_sel", int'(cur_sel), 0);
    chk("async_reset busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef ORDER_CANCEL_EN
    // Cancel in the second NEXT_LOW of a two-press order
    req_type  = 2'd2;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    chk("cancel pre next_low", int'(next_button), 0);
    cancel = 1'b1;
    bad = 0;
    begin
      int ready_at;
      ready_at = -1;
      for (int k = 71; k <= 110; k++) begin
        @(posedge clk); #1;
        cancel = 1'b0;
        if (next_button !== 1'b1 || select_button !== 1'b1 || done !== 1'b0) bad++;
        if (req_ready === 1'b1 && ready_at < 0) ready_at = k;
      end
      chk("cancel button_done_errs", bad, 0);
      chk("cancel ready_cycle", ready_at, 71 + G);
    end
    chk("cancel cur_sel", int'(cur_sel), 1);
`endif

    chk("both_low_cycles", both_low, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
